// File: rtl/autotest_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : autotest_seq_if
// Brief    : Command/status bundle between the autotest sequencer and the
//            sdspi host controller.
// Revision : 1.0 - initial release
// ============================================================================
interface autotest_seq_if;
    logic        spi_busy;
    logic        spi_err;
    logic [7:0]  spi_data_out;
    logic [31:0] spi_block_addr;
    logic        spi_r_block;
    logic        spi_r_byte;
    logic        spi_w_block;
    logic        spi_w_byte;
    logic        spi_rst;
    logic [7:0]  spi_data_in;

    modport master (
        input  spi_busy, spi_err, spi_data_out,
        output spi_block_addr, spi_r_block, spi_r_byte, spi_w_block,
               spi_w_byte, spi_rst, spi_data_in
    );

    modport slave (
        output spi_busy, spi_err, spi_data_out,
        input  spi_block_addr, spi_r_block, spi_r_byte, spi_w_block,
               spi_w_byte, spi_rst, spi_data_in
    );
endinterface
`default_nettype wire

// File: rtl/autotest_seq.sv
`default_nettype none
// ============================================================================
// Module   : autotest_seq
// Brief    : Reads test descriptors from SD, runs the UUT, writes result
//            records back. Macro AUTOTEST_TIMEOUT_EN enables the run timeout.
// Revision : 1.0 - initial release
// ============================================================================
module autotest_seq #(
    parameter int          N_PARAM_BYTES  = 6,
    parameter logic [31:0] SIGNATURE      = 32'hAABBCCDD,
    parameter logic [31:0] BASE_BLOCK     = 32'h00100000,
    parameter int          BLOCK_BYTES    = 512,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'h06E00000,
    parameter logic [31:0] SETTLE_CYCLES  = 32'h000F0000
) (
    input  wire                          clk,
    input  wire                          rst,
    autotest_seq_if.master               sd,
    output logic                         uut_ctrl_mux,
    output logic                         uut_rst,
    output logic                         uut_start,
    output logic [8*N_PARAM_BYTES-1:0]   uut_params,
    input  wire                          uut_finish,
    output logic                         done,
    output logic                         err,
    output logic [31:0]                  blk_idx,
    output logic [4:0]                   state_dbg
);

    typedef enum logic [4:0] {
        S_IDLE    = 5'd0,  S_HRST    = 5'd1,  S_HRST_W  = 5'd2,  S_RBLK    = 5'd3,
        S_RBLK_W  = 5'd4,  S_RBYTE   = 5'd5,  S_RBYTE_W = 5'd6,  S_CHECK   = 5'd7,
        S_START   = 5'd8,  S_RUN     = 5'd9,  S_SETTLE  = 5'd10, S_WBLK    = 5'd11,
        S_WBYTE   = 5'd12, S_WREQ    = 5'd13, S_WBYTE_W = 5'd14, S_WCOMMIT = 5'd15,
        S_DONE    = 5'd16
    } state_t;

    localparam logic [31:0] c_last_rd = 32'(N_PARAM_BYTES + 3);
    localparam logic [31:0] c_status  = 32'(N_PARAM_BYTES + 4);
    localparam logic [31:0] c_tim0    = 32'(N_PARAM_BYTES + 5);
    localparam logic [31:0] c_last_wr = 32'(BLOCK_BYTES - 1);

    state_t                        r_state, w_state_nxt;
    logic [31:0]                   r_blk_idx;
    logic [31:0]                   r_sig;
    logic [8*N_PARAM_BYTES-1:0]    r_params;
    logic [31:0]                   r_timer;
    logic [31:0]                   r_settle_cnt;
    logic [31:0]                   r_byte_cnt;
    logic [7:0]                    r_data_in;
    logic                          r_timeout;
    logic                          r_err_seen;
    logic                          r_err;
    logic                          w_timeout_hit;
    logic                          w_sd_state;
    logic [7:0]                    w_rec_byte;

`ifdef AUTOTEST_TIMEOUT_EN
    assign w_timeout_hit = (r_timer == TIMEOUT_CYCLES);
`else
    // Timeout disabled: never fires, the run waits for uut_finish only.
    assign w_timeout_hit = 1'b0 && (r_timer == TIMEOUT_CYCLES);
`endif

    assign w_sd_state = ((r_state >= S_HRST) && (r_state <= S_RBYTE_W)) ||
                        ((r_state >= S_WBLK) && (r_state <= S_WCOMMIT));

    assign sd.spi_block_addr = BASE_BLOCK + r_blk_idx;
    assign sd.spi_data_in    = r_data_in;
    assign uut_params        = r_params;
    assign blk_idx           = r_blk_idx;
    assign err               = r_err;
    assign state_dbg         = r_state;

    // Result record: signature, params, status, big-endian timer, zero fill.
    always_comb begin
        w_rec_byte = 8'h00;
        for (int k = 0; k < 4; k++)
            if (r_byte_cnt == 32'(k)) w_rec_byte = r_sig[8*(3-k) +: 8];
        for (int k = 0; k < N_PARAM_BYTES; k++)
            if (r_byte_cnt == 32'(4 + k)) w_rec_byte = r_params[8*(N_PARAM_BYTES-1-k) +: 8];
        if (r_byte_cnt == c_status) w_rec_byte = {6'b0, r_err_seen, r_timeout};
        for (int k = 0; k < 4; k++)
            if (r_byte_cnt == c_tim0 + 32'(k)) w_rec_byte = r_timer[8*(3-k) +: 8];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        sd.spi_rst     = 1'b0;
        sd.spi_r_block = 1'b0;
        sd.spi_r_byte  = 1'b0;
        sd.spi_w_block = 1'b0;
        sd.spi_w_byte  = 1'b0;
        uut_rst        = 1'b1;
        uut_ctrl_mux   = 1'b0;
        uut_start      = 1'b0;
        done           = 1'b0;
        case (r_state)
            S_IDLE:    w_state_nxt = S_HRST;
            S_HRST: begin
                sd.spi_rst = 1'b1;
                if (sd.spi_busy) w_state_nxt = S_HRST_W;
            end
            S_HRST_W:  if (!sd.spi_busy) w_state_nxt = S_RBLK;
            S_RBLK: begin
                sd.spi_r_block = 1'b1;
                if (sd.spi_busy) w_state_nxt = S_RBLK_W;
            end
            S_RBLK_W: begin
                sd.spi_r_block = 1'b1;
                if (!sd.spi_busy) w_state_nxt = S_RBYTE;
            end
            S_RBYTE: begin
                sd.spi_r_block = 1'b1;
                sd.spi_r_byte  = 1'b1;
                if (sd.spi_busy) w_state_nxt = S_RBYTE_W;
            end
            S_RBYTE_W: begin
                sd.spi_r_block = 1'b1;
                if (!sd.spi_busy)
                    w_state_nxt = (r_byte_cnt == c_last_rd) ? S_CHECK : S_RBYTE;
            end
            S_CHECK: begin
                uut_rst      = 1'b0;
                uut_ctrl_mux = 1'b1;
                w_state_nxt  = (r_sig == SIGNATURE) ? S_START : S_DONE;
            end
            S_START: begin
                uut_rst      = 1'b0;
                uut_ctrl_mux = 1'b1;
                uut_start    = 1'b1;
                w_state_nxt  = S_RUN;
            end
            S_RUN: begin
                uut_rst      = 1'b0;
                uut_ctrl_mux = 1'b1;
                uut_start    = 1'b1;
                if (uut_finish || w_timeout_hit) w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                uut_rst      = 1'b0;
                uut_ctrl_mux = 1'b1;
                if ((r_settle_cnt == SETTLE_CYCLES) && !sd.spi_busy) w_state_nxt = S_WBLK;
            end
            S_WBLK: begin
                sd.spi_w_block = 1'b1;
                if (!sd.spi_busy) w_state_nxt = S_WBYTE;
            end
            S_WBYTE: begin
                sd.spi_w_block = 1'b1;
                w_state_nxt    = S_WREQ;
            end
            S_WREQ: begin
                sd.spi_w_block = 1'b1;
                sd.spi_w_byte  = 1'b1;
                if (sd.spi_busy) w_state_nxt = S_WBYTE_W;
            end
            S_WBYTE_W: begin
                sd.spi_w_block = 1'b1;
                if (!sd.spi_busy)
                    w_state_nxt = (r_byte_cnt == c_last_wr) ? S_WCOMMIT : S_WBYTE;
            end
            S_WCOMMIT: if (!sd.spi_busy) w_state_nxt = S_IDLE;
            S_DONE:    done = 1'b1;
            default:   w_state_nxt = S_IDLE;
        endcase
        if (w_sd_state && sd.spi_err) w_state_nxt = S_DONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blk_idx    <= 32'd0;
            r_sig        <= 32'd0;
            r_params     <= '0;
            r_timer      <= 32'd0;
            r_settle_cnt <= 32'd0;
            r_byte_cnt   <= 32'd0;
            r_data_in    <= 8'hFF;
            r_timeout    <= 1'b0;
            r_err_seen   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_sd_state && sd.spi_err) r_err <= 1'b1;
            if ((r_state >= S_CHECK) && (r_state <= S_SETTLE) && sd.spi_err) r_err_seen <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_sig        <= 32'd0;
                    r_params     <= '0;
                    r_timer      <= 32'd0;
                    r_settle_cnt <= 32'd0;
                    r_byte_cnt   <= 32'd0;
                    r_timeout    <= 1'b0;
                    r_err_seen   <= 1'b0;
                end
                S_RBYTE_W: if (!sd.spi_busy && !sd.spi_err) begin
                    for (int k = 0; k < 4; k++)
                        if (r_byte_cnt == 32'(k)) r_sig[8*(3-k) +: 8] <= sd.spi_data_out;
                    for (int k = 0; k < N_PARAM_BYTES; k++)
                        if (r_byte_cnt == 32'(4 + k))
                            r_params[8*(N_PARAM_BYTES-1-k) +: 8] <= sd.spi_data_out;
                    r_byte_cnt <= r_byte_cnt + 32'd1;
                end
                S_CHECK:  r_byte_cnt <= 32'd0;
                S_START:  r_timer    <= 32'd0;
                S_RUN: begin
                    r_settle_cnt <= 32'd0;
                    // Finish has priority over a coincident timeout; timer freezes on exit.
                    if (!uut_finish && w_timeout_hit) r_timeout <= 1'b1;
                    if (!uut_finish && !w_timeout_hit && (r_timer != 32'hFFFF_FFFF))
                        r_timer <= r_timer + 32'd1;
                end
                S_SETTLE: if (r_settle_cnt != SETTLE_CYCLES) r_settle_cnt <= r_settle_cnt + 32'd1;
                S_WBYTE:  r_data_in <= w_rec_byte;
                S_WBYTE_W: if (!sd.spi_busy && !sd.spi_err) r_byte_cnt <= r_byte_cnt + 32'd1;
                S_WCOMMIT: if (!sd.spi_busy && !sd.spi_err) r_blk_idx <= r_blk_idx + 32'd1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
